// File: rtl/network_sequencer_pkg.sv
// network_seq_pkg: shared state encoding and sizing helpers for the network sequencer
package network_seq_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT_IN, CONV_START, CONV_WAIT, CACHE_STROBE, OUTPUT} state_t;
  localparam int DEFAULT_TIMEOUT = 1023;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/network_sequencer_sync.sv
// sample_edge_sync: 3-flop synchroniser with rising-edge tick, blind to a level already high at reset release
module sample_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic tick
);
  logic [2:0] sync_q, sync_d;
  logic seen_q, seen_d, armed_q, armed_d;
  // shift the chain; arm only after a genuine low sample has been captured
  always_comb begin
    sync_d = {sync_q[1:0], async_in};
    seen_d = 1'b1;
    armed_d = armed_q | (seen_q & ~sync_q[0]);
  end
  // synchroniser registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      seen_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      seen_q <= seen_d;
      armed_q <= armed_d;
    end
  end
  assign tick = sync_q[1] & ~sync_q[2] & armed_q;
endmodule

// File: rtl/network_sequencer.sv
// network_sequencer: layer-indexed forward-pass controller for the cached dilated causal conv chain
module network_sequencer
  import network_seq_pkg::*;
#(
  parameter int W = 16,
  parameter int NUM_LAYERS = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_clk,
  output logic                  lsb_clk,
  output logic [NUM_LAYERS-1:0] conv_rst,
  input  logic [NUM_LAYERS-1:0] conv_out_v,
  output logic [NUM_LAYERS-2:0] ac_clk,
  input  logic [W-1:0]          final_out,
  output logic [W-1:0]          sample_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic [CW-1:0]         cycle_count,
  output logic [CW-1:0]         overrun_count,
  output logic                  timeout_err
);
  localparam int KW = idx_w(NUM_LAYERS);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = '1;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc, cycle_count_q, cycle_count_d, overrun_q, overrun_d;
  logic [W-1:0] sample_out_q, sample_out_d;
  logic [NUM_LAYERS-1:0] conv_rst_q, conv_rst_d;
  logic [NUM_LAYERS-2:0] ac_q, ac_d;
  logic lsb_q, lsb_d, out_valid_q, out_valid_d, timeout_q, timeout_d, tick;
  sample_edge_sync u_sync (.clk(clk), .rst(rst), .async_in(sample_clk), .tick(tick));
  // next state, pass bookkeeping and strobes decoded from the next state so they leave a flop
  always_comb begin
    cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
    state_d = state_q;
    k_d = k_q;
    wd_d = wd_q;
    cnt_d = cnt_inc;
    sample_out_d = sample_out_q;
    out_valid_d = 1'b0;
    cycle_count_d = cycle_count_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: state_d = tick ? SHIFT_IN : IDLE;
      SHIFT_IN: begin
        state_d = CONV_START;
        k_d = '0;
        cnt_d = CW'(1);
      end
      CONV_START: begin
        state_d = CONV_WAIT;
        wd_d = '0;
      end
      CONV_WAIT:
        if (conv_out_v[k_q]) state_d = (k_q == KW'(NUM_LAYERS - 1)) ? OUTPUT : CACHE_STROBE;
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          k_d = '0;
          timeout_d = 1'b1;
        end else wd_d = wd_q + 1'b1;
      CACHE_STROBE: begin
        state_d = CONV_START;
        k_d = k_q + 1'b1;
      end
      OUTPUT: begin
        state_d = tick ? SHIFT_IN : IDLE;
        sample_out_d = final_out;
        out_valid_d = 1'b1;
        cycle_count_d = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
    if (tick && state_q != IDLE && state_q != OUTPUT && overrun_q != CMAX) overrun_d = overrun_q + 1'b1;
    lsb_d = (state_d == SHIFT_IN);
    conv_rst_d = (state_d == CONV_START) ? NUM_LAYERS'(1) << k_d : '0;
    ac_d = (state_d == CACHE_STROBE) ? (NUM_LAYERS - 1)'(1) << k_d : '0;
  end
  // state and output registers, cleared asynchronously so strobes drop at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      wd_q <= '0;
      cnt_q <= '0;
      sample_out_q <= '0;
      out_valid_q <= 1'b0;
      cycle_count_q <= '0;
      overrun_q <= '0;
      timeout_q <= 1'b0;
      lsb_q <= 1'b0;
      conv_rst_q <= '0;
      ac_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      wd_q <= wd_d;
      cnt_q <= cnt_d;
      sample_out_q <= sample_out_d;
      out_valid_q <= out_valid_d;
      cycle_count_q <= cycle_count_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      lsb_q <= lsb_d;
      conv_rst_q <= conv_rst_d;
      ac_q <= ac_d;
    end
  end
  assign lsb_clk = lsb_q;
  assign conv_rst = conv_rst_q;
  assign ac_clk = ac_q;
  assign sample_out = sample_out_q;
  assign out_valid = out_valid_q;
  assign busy = (state_q != IDLE);
  assign cycle_count = cycle_count_q;
  assign overrun_count = overrun_q;
  assign timeout_err = timeout_q;
endmodule

// File: doc/network_sequencer.md
Name: network_sequencer

Overview:
- Parametrised forward-pass controller for the cached dilated causal conv network.
- Replaces the fixed 4-layer hand-unrolled state machine with a controller for any layer count, using a layer index.
- Adds:
  - sample_clk synchronisation and edge detection;
  - a defined overrun policy;
  - a conv watchdog;
  - headroom instrumentation.
- Drives the left shift buffer strobe, per-layer conv resets and activation-cache strobes, then registers the final conv output.

Parameters:
- W, 16, sample/element width.
- NUM_LAYERS, 4, conv layers in the chain (>=2); NUM_LAYERS-1 activation caches sit between them.
- TIMEOUT, 1023, maximum CONV_WAIT cycles per layer before abort.
- CW, 16, width of the cycle and overrun counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- sample_clk  in  1  audio sample clock, asynchronous to clk.
- lsb_clk  out  1  one-cycle strobe to the left shift buffers.
- conv_rst  out  NUM_LAYERS  one-hot, one-cycle start/reset pulse per conv.
- conv_out_v  in  NUM_LAYERS  per-conv output-valid level.
- ac_clk  out  NUM_LAYERS-1  one-hot, one-cycle strobe per activation cache.
- final_out  in  W  channel-0 element of the last conv's packed output.
- sample_out  out  W  registered network output.
- out_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high whenever state != IDLE.
- cycle_count  out  CW  cycles from SHIFT_IN through OUTPUT of the last completed pass.
- overrun_count  out  CW  saturating count of dropped sample ticks.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- **Reset:**
  - State IDLE, layer index 0; all outputs 0.
  - Sync flops 0, so a sample_clk already high at reset release is not an edge.
  - Mid-pass reset drops all strobes immediately (asynchronous).
- **Sync:** 3-flop chain s1,s2,s3 on sample_clk; tick = s2 & ~s3. This gives 2-3 cycles of latency from the sample_clk edge.
- **States:** IDLE, SHIFT_IN, CONV_START, CONV_WAIT, CACHE_STROBE, OUTPUT.
- **Transitions:**
  - IDLE: tick -> SHIFT_IN.
  - SHIFT_IN -> CONV_START, with k=0.
  - CONV_START -> CONV_WAIT; the watchdog counter clears.
  - CONV_WAIT, when conv_out_v[k]=1:
    - k<NUM_LAYERS-1 -> CACHE_STROBE;
    - otherwise -> OUTPUT.
  - CACHE_STROBE -> CONV_START, with k<=k+1.
  - OUTPUT -> IDLE, or -> SHIFT_IN if tick is high that same cycle (tick accepted, not counted as overrun).
- **Strobe timing:**
  - lsb_clk, conv_rst[k] and ac_clk[k] are high exactly for the cycle(s) the FSM occupies SHIFT_IN, CONV_START and CACHE_STROBE respectively.
  - They are registered decodes: glitch-free and one-hot.
- **conv_out_v sampling:** sampled only in CONV_WAIT. The value during CONV_START is ignored, so a stale valid from the previous pass cannot skip a layer.
- **OUTPUT cycle updates (visible next cycle):**
  - sample_out <= final_out;
  - out_valid pulses;
  - cycle_count <= cycles spent in SHIFT_IN..OUTPUT inclusive.
- **Minimum latency** (every conv_out_v high on the first CONV_WAIT cycle):
  - OUTPUT occurs 3*NUM_LAYERS+1 cycles after the tick cycle;
  - sample_out/out_valid appear at 3*NUM_LAYERS+2;
  - cycle_count = 3*NUM_LAYERS+1.
- **Overrun:**
  - A tick in any state other than IDLE/OUTPUT is dropped. The pass is NOT restarted.
  - overrun_count increments and saturates at all-ones.
- **Watchdog:**
  - Abort occurs when the CONV_WAIT counter reaches TIMEOUT with conv_out_v[k] still low.
  - On abort: timeout_err<=1, state -> IDLE, k<=0; sample_out, out_valid and cycle_count are unchanged.
  - timeout_err clears only on rst; later passes run normally.
- **Widths:**
  - k is $clog2(NUM_LAYERS) bits.
  - The cycle counter saturates at all-ones rather than wrapping.

Decomposition:
- Package network_seq_pkg: state enum (6 states), a layer-index width function, and default TIMEOUT.
- Sub-module sample_edge_sync (clk, rst, async_in -> tick): 3-flop synchroniser plus rising-edge detect, reusable for the jack inputs.

Test Plan:
- **Single pass, minimum latency:** NUM_LAYERS=4, conv_out_v tied high, final_out=16'h1234, one sample_clk edge.
  - Exactly one pulse each on lsb_clk, conv_rst[0..3] and ac_clk[0..2], in order.
  - out_valid 14 cycles after tick; sample_out=16'h1234; cycle_count=13.
- **Stale valid:** conv_out_v[1] held high from the previous pass, with conv1 model raising valid 5 cycles after its conv_rst.
  - FSM waits in CONV_WAIT for conv1 rather than skipping.
  - cycle_count=13+4=17 (valid sampled in CONV_WAIT).
- **Overrun:** convs take 20 cycles each; second sample_clk edge arrives mid-pass.
  - overrun_count=1; the first pass completes untouched with a single out_valid.
  - A tick arriving in the OUTPUT cycle starts a new pass with overrun_count unchanged.
- **Watchdog:** TIMEOUT=8, conv2 never asserts valid.
  - timeout_err=1 and busy=0 after abort; no out_valid; sample_out holds its previous value.
  - The next tick with healthy convs produces a normal pass, and timeout_err stays 1.
- **Reset:**
  - rst asserted during CONV_WAIT of layer 2: all outputs 0 asynchronously.
  - sample_clk held high through reset release: no pass starts until the next rising edge.
- **NUM_LAYERS=2 build:** ac_clk is 1 bit; minimum latency gives out_valid at cycle 8, cycle_count=7.
